// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream in, registered 3x3 window out
interface sobel_window_gen_if #(
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;
  logic              win_valid;
  logic [9:0]        win_x;
  logic [8:0]        win_y;
  logic [DATA_W-1:0] data00, data01, data02;
  logic [DATA_W-1:0] data10, data11, data12;
  logic [DATA_W-1:0] data20, data21, data22;
  modport master (
    output in_valid, in_sof, in_data,
    input  win_valid, win_x, win_y,
    input  data00, data01, data02, data10, data11, data12, data20, data21, data22
  );
  modport slave (
    input  in_valid, in_sof, in_data,
    output win_valid, win_x, win_y,
    output data00, data01, data02, data10, data11, data12, data20, data21, data22
  );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 window generator with two line buffers
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 12
) (
  input logic clk,
  input logic reset,
  sobel_window_gen_if.slave s
);
  localparam int AW = $clog2(IMG_WIDTH);
  logic [9:0]        col, cx, col_nxt;
  logic [8:0]        row, cy, row_nxt;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_q, lb1_q;
  logic              eol, win;
  // coordinate of the incoming pixel (sof forces origin), next coordinate and buffer reads
  always_comb begin
    cx      = s.in_sof ? '0 : col;
    cy      = s.in_sof ? '0 : row;
    eol     = cx == 10'(IMG_WIDTH - 1);
    col_nxt = eol ? '0 : cx + 10'd1;
    row_nxt = !eol ? cy : (cy == 9'(IMG_HEIGHT - 1) ? '0 : cy + 9'd1);
    lb0_q   = lb0[cx[AW-1:0]];
    lb1_q   = lb1[cx[AW-1:0]];
    win     = s.in_valid && cx >= 10'd2 && cy >= 9'd2;
  end
  // raster position advances only on accepted pixels
  always_ff @(posedge clk)
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (s.in_valid) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  // line buffers cascade lb0 -> lb1; contents are never cleared, row gating hides stale data
  always_ff @(posedge clk)
    if (!reset && s.in_valid) begin
      lb0[cx[AW-1:0]] <= s.in_data;
      lb1[cx[AW-1:0]] <= lb0_q;
    end
  // window shift registers double as the output words; centre is registered with the strobe
  always_ff @(posedge clk)
    if (reset) begin
      s.win_valid <= 1'b0;
      s.win_x     <= '0;
      s.win_y     <= '0;
      s.data00    <= '0;
      s.data01    <= '0;
      s.data02    <= '0;
      s.data10    <= '0;
      s.data11    <= '0;
      s.data12    <= '0;
      s.data20    <= '0;
      s.data21    <= '0;
      s.data22    <= '0;
    end else begin
      s.win_valid <= win;
      if (win) begin
        s.win_x <= cx - 10'd1;
        s.win_y <= cy - 9'd1;
      end
      if (s.in_valid) begin
        s.data00 <= s.data01;
        s.data01 <= s.data02;
        s.data02 <= lb1_q;
        s.data10 <= s.data11;
        s.data11 <= s.data12;
        s.data12 <= lb0_q;
        s.data20 <= s.data21;
        s.data21 <= s.data22;
        s.data22 <= s.in_data;
      end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed checks of a 4x4 instance and a full-size 320x240 instance
module tb_sobel_window_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  int pulses = 0;
  logic [11:0] exp_d22 = '0;
  logic [9:0]  exp_wx = '0;
  logic [8:0]  exp_wy = '0;
  logic [9:0]  last_x = '0;
  logic [8:0]  last_y = '0;
  always #5 clk = ~clk;
  sobel_window_gen_if #(.DATA_W(12)) a ();
  sobel_window_gen_if #(.DATA_W(12)) b ();
  sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(12)) u4 (.clk(clk), .reset(reset), .s(a));
  sobel_window_gen #(.IMG_WIDTH(320), .IMG_HEIGHT(240), .DATA_W(12)) u320 (.clk(clk), .reset(reset), .s(b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, want);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(a.win_valid), 0);
    chk({tag, "_x"}, 32'(a.win_x), 0);
    chk({tag, "_y"}, 32'(a.win_y), 0);
    chk({tag, "_d00"}, 32'(a.data00), 0);
    chk({tag, "_d11"}, 32'(a.data11), 0);
    chk({tag, "_d22"}, 32'(a.data22), 0);
  endtask

  task automatic chk_pix(input logic [11:0] base, input int x, input int y);
    logic [11:0] d [9];
    d = '{a.data00, a.data01, a.data02, a.data10, a.data11, a.data12, a.data20, a.data21, a.data22};
    if (x >= 2 && y >= 2) begin
      chk($sformatf("win_valid(%0d,%0d)", x, y), 32'(a.win_valid), 1);
      chk($sformatf("win_x(%0d,%0d)", x, y), 32'(a.win_x), 32'(x - 1));
      chk($sformatf("win_y(%0d,%0d)", x, y), 32'(a.win_y), 32'(y - 1));
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          chk($sformatf("data%0d%0d(%0d,%0d)", r, c, x, y), 32'(d[r*3+c]),
              32'(base + 12'(16 * (y - 2 + r) + (x - 2 + c))));
      exp_wx = 10'(x - 1);
      exp_wy = 9'(y - 1);
    end else begin
      chk($sformatf("no_win(%0d,%0d)", x, y), 32'(a.win_valid), 0);
    end
    exp_d22 = base + 12'(16 * y + x);
    chk($sformatf("d22(%0d,%0d)", x, y), 32'(a.data22), 32'(exp_d22));
  endtask

  task automatic send4(input logic [11:0] base, input bit sof, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      a.in_valid = 1'b1;
      a.in_sof   = sof && i == 0;
      a.in_data  = base + 12'(16 * (i / 4) + i % 4);
      @(negedge clk);
      chk_pix(base, i % 4, i / 4);
      a.in_valid = 1'b0;
      a.in_sof   = 1'b0;
      if (stall)
        repeat ($urandom_range(0, 2)) begin
          a.in_sof  = 1'($urandom_range(0, 1));
          a.in_data = 12'($urandom);
          @(negedge clk);
          chk("stall_valid", 32'(a.win_valid), 0);
          chk("stall_d22", 32'(a.data22), 32'(exp_d22));
          chk("stall_wx", 32'(a.win_x), 32'(exp_wx));
          chk("stall_wy", 32'(a.win_y), 32'(exp_wy));
        end
      a.in_sof = 1'b0;
    end
  endtask

  initial begin
    a.in_valid = 1'b0;
    a.in_sof   = 1'b0;
    a.in_data  = '0;
    b.in_valid = 1'b0;
    b.in_sof   = 1'b0;
    b.in_data  = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    send4(12'h000, 1'b1, 16, 1'b0);
    send4(12'h100, 1'b0, 16, 1'b0);
    send4(12'h300, 1'b1, 16, 1'b1);
    send4(12'h000, 1'b1, 9, 1'b0);
    send4(12'h200, 1'b1, 16, 1'b0);
    send4(12'h400, 1'b1, 12, 1'b0);
    reset      = 1'b1;
    a.in_valid = 1'b1;
    a.in_data  = 12'hABC;
    @(negedge clk);
    reset      = 1'b0;
    a.in_valid = 1'b0;
    exp_d22 = '0;
    exp_wx  = '0;
    exp_wy  = '0;
    chk_zero("midreset");
    send4(12'h500, 1'b0, 16, 1'b0);
    for (int i = 0; i < 76800; i++) begin
      b.in_valid = 1'b1;
      b.in_sof   = i == 0;
      b.in_data  = i[11:0];
      @(negedge clk);
      if (b.win_valid) begin
        pulses++;
        last_x = b.win_x;
        last_y = b.win_y;
      end
      if (i == 642) begin
        chk("big_first_valid", 32'(b.win_valid), 1);
        chk("big_first_d00", 32'(b.data00), 0);
        chk("big_first_d11", 32'(b.data11), 32'h141);
        chk("big_first_d22", 32'(b.data22), 32'h282);
      end
    end
    b.in_valid = 1'b0;
    b.in_sof   = 1'b0;
    chk("big_last_d22", 32'(b.data22), 32'hBFF);
    @(negedge clk);
    chk("big_idle", 32'(b.win_valid), 0);
    chk("big_pulses", 32'(pulses), 75684);
    chk("big_last_x", 32'(last_x), 318);
    chk("big_last_y", 32'(last_y), 238);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that feeds the Sobel edge stage. It accepts one 12-bit RGB444 pixel per valid cycle in raster order. Two line buffers keep the previous rows, and the block presents the full 3x3 neighbourhood as nine registered words, data00..data22, plus a window-valid strobe and the centre coordinates. Edge detection downstream consumes these words combinationally, one window per accepted pixel.

## Interface
- IMG_WIDTH, 320, pixels per line (minimum 3)
- IMG_HEIGHT, 240, lines per frame (minimum 3)
- DATA_W, 12, pixel width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pixel accepted this cycle when high
- in_sof  in  1  qualifies in_valid; marks this pixel as (0,0) of a new frame
- in_data  in  DATA_W  pixel value
- win_valid  out  1  one-cycle pulse; data00..data22 hold a complete window
- win_x  out  10  centre column of the window
- win_y  out  9  centre row of the window
- data00..data22  out  DATA_W each  window; first digit is the row (0 = oldest, y-2), second digit is the column (0 = oldest, x-2); data22 is the newest pixel

## Operation
- Internal column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) give the coordinate of the pixel being accepted.
- On an accepted pixel:
  - if in_sof=1, the pixel is (0,0), regardless of the counters;
  - afterwards col increments; at IMG_WIDTH-1, col wraps to 0 and row increments;
  - at (IMG_WIDTH-1, IMG_HEIGHT-1), the next coordinate is (0,0), so the frame wraps without in_sof.
- Line buffers lb0 (row y-1) and lb1 (row y-2) are single-port-per-side arrays of IMG_WIDTH x DATA_W. On an accepted pixel at column c:
  - read lb0[c] and lb1[c];
  - write lb1[c] <= old lb0[c] and lb0[c] <= in_data.
- Three 3-stage shift registers, one per row, shift on each accepted pixel:
  - row2 takes in_data;
  - row1 takes lb0[c];
  - row0 takes lb1[c].
- Column 2 of each shift register is the newest entry.
- Shift registers are not cleared at line start. Windows with x<2 are suppressed by win_valid gating, not by data values.
- win_valid=1 for an accepted pixel at (x,y) only when x>=2 and y>=2. In that case win_x=x-1 and win_y=y-1.
- Per frame there are exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid pulses.
- Line-buffer contents are not reset. Stale data is never exposed, because row<2 suppresses win_valid.

## Timing
- Latency is 1 cycle: a pixel accepted at edge n appears at data22, with win_valid, after edge n+1.
- in_valid=0 cycles are stalls:
  - counters, shift registers and buffers hold;
  - data00..data22, win_x and win_y hold their last values;
  - win_valid=0.
- Back-to-back in_valid is sustained at 1 pixel per cycle with no bubble.
- in_sof asserted with in_valid mid-frame:
  - the pixel is (0,0) and the old row count is discarded;
  - win_valid stays low until a new row 2, column 2 is reached.
- in_sof without in_valid is ignored.
- Reset, including mid-line:
  - next cycle: col=0, row=0, win_valid=0, win_x=0, win_y=0, data00..data22=0;
  - the first pixel accepted after reset is (0,0) even without in_sof.
- reset has priority over in_valid in the same cycle; that pixel is dropped.
- Widths: win_x and win_y are unsigned. IMG_WIDTH ≤ 1024 and IMG_HEIGHT ≤ 512.

## Test plan
- Basic 4x4 frame: IMG_WIDTH=4, IMG_HEIGHT=4, pixel (x,y)=16y+x, continuous valid, sof on the first pixel.
  - The first win_valid comes one cycle after pixel (2,2).
  - Window: win_x=1, win_y=1, data00=0x000, data01=0x001, data02=0x002, data10=0x010, data11=0x011, data12=0x012, data20=0x020, data21=0x021, data22=0x022.
  - The frame produces 4 pulses total; the last has centre (2,2) and data22=0x033.
- Stalls: same frame with random in_valid gaps.
  - Window values and order are identical to the basic case.
  - win_valid never asserts on a stall cycle.
  - Outputs hold during gaps.
- Frame wrap: send two 4x4 frames back-to-back with sof only on the first.
  - The second frame yields 4 pulses with identical centres.
  - The values are those of the second frame.
  - There is no pulse at rows 0-1 of the second frame.
- Mid-frame sof: assert sof at pixel (1,2) of frame 1.
  - No win_valid occurs until the new (2,2).
  - The following windows use only post-sof pixels.
- Reset mid-line: assert reset after pixel (3,2).
  - The next cycle shows all outputs 0.
  - The following pixels restart at (0,0).
  - A reset in the same cycle as in_valid drops that pixel.
- Default size: a 320x240 ramp frame gives 318*238=75684 pulses.
  - The last pulse has win_x=318 and win_y=238.
